// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin N-port RAM arbiter with testbench override and sticky halt
module ram_arbiter #(
  parameter int NPORTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NPORTS-1:0]    memREN,
  input  logic [NPORTS-1:0]    memWEN,
  input  logic [NPORTS*AW-1:0] memaddr,
  input  logic [NPORTS*DW-1:0] memstore,
  output logic [NPORTS-1:0]    memwait,
  output logic [DW-1:0]        memload,
  output logic [NPORTS-1:0]    memerr,
  input  logic [NPORTS-1:0]    halt_in,
  output logic                 halt,
  input  logic                 tbCTRL,
  input  logic                 tbREN,
  input  logic                 tbWEN,
  input  logic [AW-1:0]        tbaddr,
  input  logic [DW-1:0]        tbstore,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [DW-1:0]        ramstore,
  input  logic [DW-1:0]        ramload,
  input  logic [1:0]           ramstate
);

  localparam int OW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic            halt_q, halt_d;

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] owner_oh;
  logic              own_req, own_ren, own_wen;
  logic [AW-1:0]     own_addr;
  logic [DW-1:0]     own_store;
  logic              found;
  logic [OW-1:0]     pick;
  logic              done;

  assign req = memREN | memWEN;

  always_comb begin
    own_ren   = 1'b0;
    own_wen   = 1'b0;
    own_addr  = '0;
    own_store = '0;
    owner_oh  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (int'(owner_q) == i) begin
        own_ren     = memREN[i];
        own_wen     = memWEN[i];
        own_addr    = memaddr[i*AW +: AW];
        own_store   = memstore[i*DW +: DW];
        owner_oh[i] = 1'b1;
      end
    end
    own_req = own_ren | own_wen;
  end

  // Scan last+1, last+2, ... with wrap; first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= NPORTS; k++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (!found && req[i] && i == (int'(last_q) + k) % NPORTS) begin
          found = 1'b1;
          pick  = OW'(i);
        end
      end
    end
  end

  // ACCESS (2) and ERROR (3) both end the transfer; bit 1 marks them.
  assign done = (state_q == GRANT) && own_req && !tbCTRL && ramstate[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    halt_d  = halt_q | (&halt_in);
    if (tbCTRL) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_d = GRANT;
            owner_d = pick;
          end
        end
        GRANT: begin
          if (!own_req) begin
            state_d = IDLE;
          end else if (ramstate[1]) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NPORTS - 1);
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    if (tbCTRL) begin
      ramREN   = tbREN;
      ramWEN   = tbWEN;
      ramaddr  = tbaddr;
      ramstore = tbstore;
    end else begin
      ramREN   = (state_q == GRANT) && own_ren && !own_wen;
      ramWEN   = (state_q == GRANT) && own_wen;
      ramaddr  = own_addr;
      ramstore = own_store;
    end
  end

  assign memwait = req & ~(done ? owner_oh : '0);
  assign memerr  = (done && ramstate[0]) ? owner_oh : '0;
  assign memload = ramload;
  assign halt    = halt_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised N-port RAM arbiter that sits between the processor side (one memory port per core or cache) and the single shared `ram`/`sdram` port at system top. It grants ports round-robin and holds each grant until the RAM completes the transfer. It also provides a testbench override that takes RAM control absolutely, and combines the per-core halt signals into one registered system halt. It replaces the two-way, single-requester `tbCTRL` mux at system top.

## Interface
- `NPORTS`, default 2: number of requesting ports, 1..8.
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `memREN` in NPORTS: per-port read request.
- `memWEN` in NPORTS: per-port write request.
- `memaddr` in NPORTS*AW: port i address at bits [i*AW +: AW].
- `memstore` in NPORTS*DW: port i write data at bits [i*DW +: DW].
- `memwait` out NPORTS: per-port wait, high while the port's request is not yet done.
- `memload` out DW: `ramload`, broadcast to all ports.
- `memerr` out NPORTS: one-cycle pulse when the port's transfer ended in ERROR.
- `halt_in` in NPORTS: per-core halt.
- `halt` out 1: registered, sticky AND of `halt_in`.
- `tbCTRL` in 1: testbench owns the RAM.
- `tbREN` in 1: testbench read request.
- `tbWEN` in 1: testbench write request.
- `tbaddr` in AW: testbench address.
- `tbstore` in DW: testbench write data.
- `ramREN` out 1: RAM read request.
- `ramWEN` out 1: RAM write request.
- `ramaddr` out AW: RAM address.
- `ramstore` out DW: RAM write data.
- `ramload` in DW: RAM read data.
- `ramstate` in 2: RAM status; FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- Request: port i requests when `memREN[i] | memWEN[i]`. If both are high, the access is a write: WEN wins and REN is suppressed to the RAM.
- FSM states: IDLE and GRANT. Registers: `owner` (clog2 NPORTS bits) and `last` (last completed port).
- IDLE, `tbCTRL`=0, any request: pick the first requesting port scanning `last+1, last+2, …` with wrap modulo NPORTS. Set `owner`, go to GRANT. No RAM request is driven in IDLE.
- GRANT, RAM drive: drive `ramREN`/`ramWEN`/`ramaddr`/`ramstore` from `owner`.
  - `ramstate`==ACCESS: complete the transfer. Deassert `memwait[owner]` that cycle, `last<=owner`, go to IDLE.
  - `ramstate`==ERROR: same as ACCESS, and additionally pulse `memerr[owner]`.
  - FREE or BUSY: stay in GRANT.
- GRANT, owner drops both REN and WEN (abort): go to IDLE. `last` is unchanged. No `memwait` or `memerr` effect.
- `tbCTRL`=1: RAM outputs come combinationally from the tb* inputs in any state.
  - FSM forced to IDLE next cycle; an in-flight transfer is abandoned and `last` is unchanged.
  - No new grant while `tbCTRL`=1.
  - All `memwait` bits for requesting ports stay high.
- `memwait[i]` = request(i) & ~(state==GRANT & owner==i & ramstate∈{ACCESS,ERROR} & ~tbCTRL).
- Halt: `halt` <= `halt` | (&`halt_in`). Once high it stays high until reset.
- NPORTS=1: arbitration is trivial and `owner` is always 0. The IDLE→GRANT cycle is still taken, so timing is identical to the multi-port case.

## Timing
- Reset values:
  - `state`=IDLE, `owner`=0, `last`=NPORTS-1, so port 0 wins first.
  - `halt`=0, `memerr`=0, `ramREN`=`ramWEN`=0.
  - `ramaddr` and `ramstore` = port 0 inputs, which is a don't-care since both requests are low.
  - `memwait` = current requests, since it is combinational.
- Latency: request seen in cycle n (IDLE) → RAM request driven from cycle n+1. With the RAM returning ACCESS k cycles after the request appears, `memwait` falls in cycle n+1+k and `memload` is valid that same cycle.
- Back-to-back: after completion the FSM spends one IDLE cycle before the next grant. Minimum service period per transfer is 2 cycles (k=0).
- Reset mid-transfer: all outputs take their reset values immediately (asynchronous) and the RAM request drops.
- `tbCTRL` rise mid-transfer: RAM control switches the same cycle; the abandoned port re-arbitrates after `tbCTRL` falls.
- `halt` is registered: 1-cycle delay after all `halt_in` go high.

## Test plan
- Reset: release `nRST` with no requests → `ramREN`=`ramWEN`=0, `halt`=0, `memerr`=0, FSM in IDLE.
- Single read: port 0 reads addr 0x40, RAM holds ACCESS after 2 BUSY cycles returning 0xDEADBEEF → `ramaddr`=0x40 from cycle 1, `memwait[0]` low in cycle 3 with `memload`=0xDEADBEEF.
- Round robin: NPORTS=4, all ports request continuously, 1-cycle RAM → grants in order 0,1,2,3,0. Each port served once per 8 cycles, and `memwait` of the served port drops exactly once.
- Priority and abort:
  - Port 1 asserts REN and WEN to 0x80 with `store`=0x5 → `ramWEN`=1, `ramREN`=0, `ramstore`=0x5.
  - Port 1 drops its request during BUSY → FSM returns to IDLE and `last` is unchanged; the next grant goes to port 0 if it is requesting.
- Testbench override: `tbCTRL`=1 mid-transfer of port 0 with `tbaddr`=0x100 and `tbWEN`=1 → `ramaddr`=0x100 and `ramWEN`=1 the same cycle, `memwait[0]` stays high. After `tbCTRL` falls, port 0 is regranted and completes.
- Error and halt:
  - `ramstate`=ERROR on port 2's grant → `memerr[2]` pulses for one cycle and `memwait[2]` drops.
  - All `halt_in` high for one cycle then low → `halt`=1 one cycle later and stays 1.
